// File: rtl/vedic2_mul.sv
// Registered 2x2 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier leaf cell.
// Define VEDIC2_CHECK_EN to build a parallel behavioural reference and sticky err flag.

module vedic2_ha (
   input  logic x,
   input  logic y,
   output logic sum,
   output logic carry
);
   assign sum   = x ^ y;
   assign carry = x & y;
endmodule

module vedic2_mul (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] s,
   output logic       out_valid,
   output logic       err
);
   logic       p0;
   logic       p1;
   logic       p2;
   logic       p3;
   logic       c1;
   logic [3:0] prod;

   // Vertical terms on the outer bits, crosswise terms feed the middle column.
   assign p0 = a[0] & b[0];
   assign p1 = a[1] & b[0];
   assign p2 = a[0] & b[1];
   assign p3 = a[1] & b[1];

   assign prod[0] = p0;

   vedic2_ha u_ha1 (
      .x     (p1),
      .y     (p2),
      .sum   (prod[1]),
      .carry (c1)
   );

   vedic2_ha u_ha2 (
      .x     (p3),
      .y     (c1),
      .sum   (prod[2]),
      .carry (prod[3])
   );

   logic [3:0] s_reg;
   logic       valid_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_reg     <= 4'b0000;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= in_valid;
         if (in_valid) begin
            s_reg <= prod;
         end
      end
   end

   assign s         = s_reg;
   assign out_valid = valid_reg;

`ifdef VEDIC2_CHECK_EN
   logic [3:0] ref_reg;
   logic       err_reg;

   // Reference is loaded under the same qualifier so both registers hold the same pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_reg <= 4'b0000;
         err_reg <= 1'b0;
      end else begin
         if (in_valid) begin
            ref_reg <= {2'b00, a} * {2'b00, b};
         end
         if (valid_reg && (s_reg != ref_reg)) begin
            err_reg <= 1'b1;
         end
      end
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vedic2_mul.sv
// Directed scoreboard bench for vedic2_mul: reset, exhaustive sweep, hold,
// back-to-back and mid-stream reset.

module tb_vedic2_mul;
   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [1:0] a;
   logic [1:0] b;
   logic [3:0] s;
   logic       out_valid;
   logic       err;

   int checks;
   int failures;

   logic [3:0] held_s;
   logic [4:0] sb_q[$];

   vedic2_mul dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .s         (s),
      .out_valid (out_valid),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Drive one pair, push the expected result, then pop and compare after the edge.
   task automatic step(input logic v, input logic [1:0] x, input logic [1:0] y, input string tag);
      logic [4:0] e;
      in_valid = v;
      a        = x;
      b        = y;
      if (v) held_s = 4'(int'(x) * int'(y));
      sb_q.push_back({v, held_s});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 4'd1, 4'd0);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_s"}, s, e[3:0]);
         check({tag, "_ov"}, {3'b000, out_valid}, {3'b000, e[4]});
         check({tag, "_err"}, {3'b000, err}, 4'd0);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      held_s   = 4'd0;
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 2'd3;
      b        = 2'd3;

      // Reset applies before any clock edge.
      #1;
      check("rst_async_s", s, 4'd0);
      check("rst_async_ov", {3'b000, out_valid}, 4'd0);
      check("rst_async_err", {3'b000, err}, 4'd0);
      @(posedge clk);
      #1;
      check("rst_held_s", s, 4'd0);
      check("rst_held_ov", {3'b000, out_valid}, 4'd0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            step(1'b1, 2'(i), 2'(j), $sformatf("sweep_%0dx%0d", i, j));
         end
      end

      step(1'b1, 2'd2, 2'd1, "hold_load");
      step(1'b0, 2'd3, 2'd3, "hold_idle1");
      step(1'b0, 2'd3, 2'd3, "hold_idle2");

      step(1'b1, 2'd3, 2'd3, "b2b_3x3");
      step(1'b1, 2'd0, 2'd3, "b2b_0x3");
      step(1'b1, 2'd2, 2'd1, "b2b_2x1");

      step(1'b1, 2'd3, 2'd3, "mid_pre");
      in_valid = 1'b1;
      a        = 2'd2;
      b        = 2'd3;
      #2;
      rst = 1'b1;
      #1;
      held_s = 4'd0;
      check("mid_rst_s", s, 4'd0);
      check("mid_rst_ov", {3'b000, out_valid}, 4'd0);
      check("mid_rst_err", {3'b000, err}, 4'd0);
      #1;
      rst = 1'b0;
      step(1'b1, 2'd2, 2'd3, "mid_post");
      step(1'b0, 2'd1, 2'd1, "mid_idle");

      check("sb_drained", 4'(sb_q.size()), 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
